// File: rtl/pid_output_processor.sv
// pid_output_processor: turns the time-multiplexed signed PID stream into double-buffered
// H-bridge PWM with a dead period on direction reversal and a per-channel watchdog.
module pid_output_processor #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CHN     = 4,
  parameter int CHN_WIDTH   = 3,
  parameter int PWM_TOP     = 1500,
  parameter int WDT_PERIODS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pid_valid_o,
  input  logic [CHN_WIDTH-1:0]  pid_chn_o,
  input  logic [DATA_WIDTH-1:0] pid_data_o,
  output logic [NUM_CHN-1:0]    pwm_a,
  output logic [NUM_CHN-1:0]    pwm_b,
  output logic                  period_start,
  output logic                  frame_done,
  output logic [NUM_CHN-1:0]    wdt_trip,
  output logic                  chn_err
);
  localparam int DW = $clog2(PWM_TOP + 1);
  localparam int CW = $clog2(PWM_TOP);
  localparam int WW = $clog2(WDT_PERIODS + 1);
  typedef enum logic {RUN, DEAD} state_t;
  logic [CW-1:0] cnt;
  logic [NUM_CHN-1:0] mask, mask_nx;
  logic bnd, accept, dir_in;
  logic [DATA_WIDTH-1:0] mag;
  logic [DW-1:0] duty_in;
  assign bnd = cnt == CW'(PWM_TOP - 1);
  assign accept = pid_valid_o && 32'(pid_chn_o) < NUM_CHN;
  assign dir_in = pid_data_o[DATA_WIDTH-1];
  // the most-negative word has no positive twin, so it saturates to the largest positive magnitude
  assign mag = !dir_in ? pid_data_o :
               pid_data_o == {1'b1, {(DATA_WIDTH-1){1'b0}}} ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
               -pid_data_o;
  assign duty_in = mag > DATA_WIDTH'(PWM_TOP) ? DW'(PWM_TOP) : DW'(mag);
  assign mask_nx = mask | (accept ? NUM_CHN'(1) << pid_chn_o : '0);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      mask         <= '0;
      period_start <= 1'b0;
      frame_done   <= 1'b0;
      chn_err      <= 1'b0;
    end else begin
      cnt          <= bnd ? '0 : cnt + 1'b1;
      period_start <= cnt == '0;
      frame_done   <= &mask_nx;
      mask         <= &mask_nx ? '0 : mask_nx;
      chn_err      <= chn_err | (pid_valid_o && !accept);
    end
  end
  for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
    state_t st, st_nx;
    logic [DW-1:0] sh_duty, act_duty, act_duty_nx;
    logic sh_dir, act_dir, act_dir_nx, hit, a_q, b_q;
    logic [WW-1:0] wdt;
    assign hit = accept && pid_chn_o == CHN_WIDTH'(c);
    assign wdt_trip[c] = wdt == WW'(WDT_PERIODS);
    assign pwm_a[c] = a_q;
    assign pwm_b[c] = b_q;
    always_comb begin
      st_nx       = st;
      act_duty_nx = act_duty;
      act_dir_nx  = act_dir;
      if (bnd && st == DEAD) begin
        st_nx       = RUN;
        act_dir_nx  = sh_dir;
        act_duty_nx = wdt_trip[c] ? '0 : sh_duty;
      end else if (bnd && wdt_trip[c]) begin
        act_duty_nx = '0;
      end else if (bnd && sh_dir != act_dir && sh_duty != '0) begin
        st_nx       = DEAD;
        act_duty_nx = '0;
      end else if (bnd) begin
        act_duty_nx = sh_duty;
        act_dir_nx  = sh_duty != '0 ? sh_dir : act_dir;
      end
    end
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st       <= RUN;
        sh_duty  <= '0;
        sh_dir   <= 1'b0;
        act_duty <= '0;
        act_dir  <= 1'b0;
        wdt      <= '0;
        a_q      <= 1'b0;
        b_q      <= 1'b0;
      end else begin
        st       <= st_nx;
        act_duty <= act_duty_nx;
        act_dir  <= act_dir_nx;
        if (hit) begin
          sh_duty <= duty_in;
          sh_dir  <= dir_in;
        end
        wdt <= hit ? '0 : (bnd && !wdt_trip[c]) ? wdt + 1'b1 : wdt;
        a_q <= DW'(cnt) < act_duty && !act_dir;
        b_q <= DW'(cnt) < act_duty && act_dir;
      end
    end
  end
endmodule

// File: tb/tb_pid_output_processor.sv
// tb_pid_output_processor: directed plus random words checked every cycle against a
// behavioural model of shadow/active duty, dead period, watchdog and frame tracking.
module tb_pid_output_processor;
  localparam int P = 1500;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, rstn = 1'b0, pid_valid_o = 1'b0;
  logic [2:0] pid_chn_o = '0;
  logic [15:0] pid_data_o = '0;
  logic [3:0] pwm_a, pwm_b, wdt_trip;
  logic period_start, frame_done, chn_err;
  int n_chk = 0, n_fail = 0;
  int m_cnt;
  int sh_duty[N], act_duty[N], wdt[N];
  bit sh_dir[N], act_dir[N], dead[N];
  bit [3:0] mask;
  bit e_err;
  logic [14:0] exp_out;
  int hi_a[N], hi_b[N];

  always #5 clk = ~clk;

  pid_output_processor dut (
    .clk(clk), .rstn(rstn), .pid_valid_o(pid_valid_o), .pid_chn_o(pid_chn_o),
    .pid_data_o(pid_data_o), .pwm_a(pwm_a), .pwm_b(pwm_b), .period_start(period_start),
    .frame_done(frame_done), .wdt_trip(wdt_trip), .chn_err(chn_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_duty(input logic [15:0] d);
    int v = $signed(d);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v > P ? P : v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; mask = '0; e_err = 0;
    for (int c = 0; c < N; c++) begin
      sh_duty[c] = 0; act_duty[c] = 0; wdt[c] = 0;
      sh_dir[c] = 0; act_dir[c] = 0; dead[c] = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [2:0] ch, input logic [15:0] d);
    bit acc = v && int'(ch) < N;
    bit [3:0] e_a, e_b, e_trip;
    bit e_ps, e_fd, trip;
    for (int c = 0; c < N; c++) begin
      e_a[c] = m_cnt < act_duty[c] && !act_dir[c];
      e_b[c] = m_cnt < act_duty[c] && act_dir[c];
    end
    e_ps = m_cnt == 0;
    e_fd = 0;
    if (v && int'(ch) >= N) e_err = 1;
    if (m_cnt == P - 1) begin
      for (int c = 0; c < N; c++) begin
        trip = wdt[c] == W;
        if (dead[c]) begin
          dead[c] = 0; act_dir[c] = sh_dir[c]; act_duty[c] = trip ? 0 : sh_duty[c];
        end else if (trip) act_duty[c] = 0;
        else if (sh_dir[c] != act_dir[c] && sh_duty[c] != 0) begin
          dead[c] = 1; act_duty[c] = 0;
        end else begin
          act_duty[c] = sh_duty[c];
          if (sh_duty[c] != 0) act_dir[c] = sh_dir[c];
        end
        if (wdt[c] < W) wdt[c]++;
      end
    end
    if (acc) begin
      wdt[ch] = 0;
      sh_duty[ch] = to_duty(d);
      sh_dir[ch] = d[15];
      mask[ch] = 1'b1;
      if (&mask) begin e_fd = 1; mask = '0; end
    end
    for (int c = 0; c < N; c++) e_trip[c] = wdt[c] == W;
    m_cnt = (m_cnt + 1) % P;
    exp_out = {e_a, e_b, e_ps, e_fd, e_trip, e_err};
  endtask

  task automatic step(input logic v, input logic [2:0] ch, input logic [15:0] d);
    pid_valid_o = v; pid_chn_o = ch; pid_data_o = d;
    @(posedge clk);
    model_edge(v, ch, d);
    @(negedge clk);
    chk("outs", {pwm_a, pwm_b, period_start, frame_done, wdt_trip, chn_err}, exp_out);
    for (int c = 0; c < N; c++) begin
      hi_a[c] += int'(pwm_a[c]);
      hi_b[c] += int'(pwm_b[c]);
    end
    pid_valid_o = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 3'd0, 16'd0);
  endtask

  initial begin
    int dv;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outs", {pwm_a, pwm_b, period_start, frame_done, wdt_trip, chn_err}, 0);
    rstn = 1'b1;
    step(1'b1, 3'd0, 16'd300);
    step(1'b1, 3'd1, 16'd1500);
    step(1'b1, 3'd2, 16'd2000);
    step(1'b1, 3'd3, 16'd0);
    run(P - 4);
    for (int c = 0; c < N; c++) begin hi_a[c] = 0; hi_b[c] = 0; end
    run(P);
    chk("duty_ch0", hi_a[0], 300);
    chk("duty_ch1", hi_a[1], 1500);
    chk("duty_ch2", hi_a[2], 1500);
    chk("duty_ch3", hi_a[3], 0);
    chk("pwm_b_idle", hi_b[0] + hi_b[1] + hi_b[2] + hi_b[3], 0);
    step(1'b1, 3'd1, 16'd500);
    run(10);
    step(1'b1, 3'd1, 16'hFE0C);
    run(3 * P);
    step(1'b1, 3'd2, 16'h8000);
    run(2 * P);
    step(1'b1, 3'd0, 16'd700);
    run(11 * P);
    chk("wdt_all", wdt_trip, 4'hF);
    step(1'b1, 3'd0, 16'd700);
    chk("wdt_clear0", wdt_trip, 4'hE);
    run(2 * P);
    while (m_cnt != P - 1) step(1'b0, 3'd0, 16'd0);
    step(1'b1, 3'd0, 16'd100);
    run(2 * P + 2);
    step(1'b1, 3'd5, 16'd1234);
    chk("chn_err_set", chn_err, 1);
    run(5);
    chk("chn_err_sticky", chn_err, 1);
    for (int i = 0; i < 6 * P; i++) begin
      case ($urandom_range(0, 3))
        0: dv = int'($urandom_range(0, 1600));
        1: dv = -int'($urandom_range(0, 1600));
        2: dv = 32'hFFFF8000;
        default: dv = int'($urandom);
      endcase
      step($urandom_range(0, 99) < 2, 3'($urandom_range(0, 7)), 16'(dv));
    end
    step(1'b1, 3'd0, 16'd1500);
    run(2 * P + 10);
    chk("pre_rst_pwm0", pwm_a[0], 1);
    #3 rstn = 1'b0;
    #1 chk("async_rst", {pwm_a, pwm_b, chn_err}, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
